// File: rtl/instr_fetch_mem.sv
// Instruction memory for the RISC-16 core: a registered fetch port with stall hold,
// a loader write port, and a clear sequencer that zeroes every word after reset or on request.
module instr_fetch_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_pc_out,
  input  logic              i_stall,
  output logic [DATA_W-1:0] o_instr_out,
  output logic              o_instr_valid,
  output logic              o_ready,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_clear_req,
  output logic              o_load_ignored
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_clrCnt;
  logic [ADDR_W-1:0] w_nextClrCnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_clrWe;
  logic              w_loadWe;
  logic              w_loadDrop;
  logic              w_fetchAccept;
  logic [DATA_W-1:0] w_fetchData;

  logic [DATA_W-1:0] r_instrOut;
  logic              r_instrValid;
  logic              r_ready;
  logic              r_loadIgnored;

  always_comb begin
    w_nextState   = r_state;
    w_nextClrCnt  = r_clrCnt;
    w_clrWe       = 1'b0;
    w_loadWe      = 1'b0;
    w_loadDrop    = 1'b0;
    w_fetchAccept = 1'b0;
    w_fetchData   = r_mem[i_pc_out];

    case (r_state)
      ST_CLEAR: begin
        w_clrWe    = 1'b1;
        w_loadDrop = i_load_en;
        if (i_clear_req) begin
          w_nextClrCnt = '0;
        end else if (r_clrCnt == {ADDR_W{1'b1}}) begin
          w_nextState  = ST_READY;
          w_nextClrCnt = '0;
        end else begin
          w_nextClrCnt = r_clrCnt + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (i_clear_req) begin
          w_nextState  = ST_CLEAR;
          w_nextClrCnt = '0;
          w_loadDrop   = i_load_en;
        end else begin
          w_loadWe      = i_load_en;
          w_fetchAccept = i_fetch_req;
        end
      end
      default: begin
        w_nextState  = ST_CLEAR;
        w_nextClrCnt = '0;
      end
    endcase

    // Write-first: a fetch that hits the word being loaded this cycle sees the new data.
    if (w_loadWe && (i_load_addr == i_pc_out)) begin
      w_fetchData = i_load_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_clrWe) begin
      r_mem[r_clrCnt] <= '0;
    end else if (w_loadWe) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_CLEAR;
      r_clrCnt      <= '0;
      r_ready       <= 1'b0;
      r_instrOut    <= '0;
      r_instrValid  <= 1'b0;
      r_loadIgnored <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_clrCnt      <= w_nextClrCnt;
      r_ready       <= (w_nextState == ST_READY);
      r_loadIgnored <= w_loadDrop;
      // Stall freezes the response; the requester re-presents any fetch afterwards.
      if (!i_stall) begin
        r_instrValid <= w_fetchAccept;
        if (w_fetchAccept) begin
          r_instrOut <= w_fetchData;
        end
      end
    end
  end

  assign o_instr_out    = r_instrOut;
  assign o_instr_valid  = r_instrValid;
  assign o_ready        = r_ready;
  assign o_load_ignored = r_loadIgnored;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem (16 words x 16 bits): fetch responses are
// queued at issue time and checked by an independent monitor; control outputs are checked directly.
module tb_instr_fetch_mem;

  logic        clk;
  logic        rst_n;
  logic        i_fetch_req;
  logic [3:0]  i_pc_out;
  logic        i_stall;
  logic [15:0] o_instr_out;
  logic        o_instr_valid;
  logic        o_ready;
  logic        i_load_en;
  logic [3:0]  i_load_addr;
  logic [15:0] i_load_data;
  logic        i_clear_req;
  logic        o_load_ignored;

  logic [15:0] expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic        stallAtEdge;
  logic [15:0] expData;

  instr_fetch_mem #(
    .DATA_W(16),
    .ADDR_W(4)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_fetch_req    (i_fetch_req),
    .i_pc_out       (i_pc_out),
    .i_stall        (i_stall),
    .o_instr_out    (o_instr_out),
    .o_instr_valid  (o_instr_valid),
    .o_ready        (o_ready),
    .i_load_en      (i_load_en),
    .i_load_addr    (i_load_addr),
    .i_load_data    (i_load_data),
    .i_clear_req    (i_clear_req),
    .o_load_ignored (o_load_ignored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and returns at the next falling edge.
  task automatic applyStimulus(input logic fetchReq, input logic [3:0] pc, input logic stall,
                               input logic loadEn, input logic [3:0] loadAddr,
                               input logic [15:0] loadData, input logic clearReq);
    i_fetch_req = fetchReq;
    i_pc_out    = pc;
    i_stall     = stall;
    i_load_en   = loadEn;
    i_load_addr = loadAddr;
    i_load_data = loadData;
    i_clear_req = clearReq;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
  endtask

  task automatic printSummary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  // A fresh response exists only after an edge that saw stall low and left valid high.
  always @(posedge clk) begin
    stallAtEdge = i_stall;
    #1;
    if (!stallAtEdge && o_instr_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL fetch_unexpected: got 0x%0h, expected no response", o_instr_out);
      end else begin
        expData = expQ.pop_front();
        checkOutput("fetch_data", {16'h0, o_instr_out}, {16'h0, expData});
      end
    end
  end

  initial begin
    #50000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    printSummary();
    $finish;
  end

  initial begin
    rst_n       = 1'b1;
    i_fetch_req = 1'b0;
    i_pc_out    = 4'd0;
    i_stall     = 1'b0;
    i_load_en   = 1'b0;
    i_load_addr = 4'd0;
    i_load_data = 16'h0000;
    i_clear_req = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_ready", o_ready, 0);
    checkOutput("reset_valid", o_instr_valid, 0);
    checkOutput("reset_instr", o_instr_out, 0);
    checkOutput("reset_ldign", o_load_ignored, 0);

    // Power-up clear: fetches are ignored, ready rises on the 16th edge.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
      checkOutput("clear_ready", o_ready, (i == 16));
      checkOutput("clear_valid", o_instr_valid, 0);
    end

    for (int a = 0; a < 16; a++) begin
      expQ.push_back(16'h0000);
      applyStimulus(1'b1, 4'(a), 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    end
    idle();
    checkOutput("idle_valid", o_instr_valid, 0);

    // Loads followed by back-to-back fetches.
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 16'h1234, 1'b0);
    expQ.push_back(16'hBEEF);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    expQ.push_back(16'h1234);
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    idle();

    // Write-first hit, later re-read, and a load to a different address during a fetch.
    expQ.push_back(16'hA5A5);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b1, 4'd5, 16'hA5A5, 1'b0);
    idle();
    expQ.push_back(16'hA5A5);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    expQ.push_back(16'hBEEF);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b1, 4'd6, 16'h6666, 1'b0);
    expQ.push_back(16'h6666);
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    idle();

    // Stall holds the response while pc_out keeps changing.
    expQ.push_back(16'hBEEF);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 4'(6 + k), 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0);
      checkOutput("stall_instr", o_instr_out, 16'hBEEF);
      checkOutput("stall_valid", o_instr_valid, 1);
    end
    expQ.push_back(16'h1234);
    applyStimulus(1'b1, 4'd4, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    idle();

    // Clear request with a colliding load, then a load on the final clear cycle.
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 16'h7777, 1'b1);
    checkOutput("clrreq_ldign", o_load_ignored, 1);
    checkOutput("clrreq_ready", o_ready, 0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 4'd3, 1'b0, (i == 16), 4'd2, 16'hDEAD, 1'b0);
      checkOutput("reclear_ready", o_ready, (i == 16));
      checkOutput("reclear_valid", o_instr_valid, 0);
      if (i < 16) checkOutput("reclear_ldign", o_load_ignored, 0);
    end
    checkOutput("lastclr_ldign", o_load_ignored, 1);
    idle();
    checkOutput("ldign_pulse_end", o_load_ignored, 0);
    expQ.push_back(16'h0000);
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    expQ.push_back(16'h0000);
    applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    expQ.push_back(16'h0000);
    applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    idle();

    // Valid response, then clear, then asynchronous reset in the middle of the clear.
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 16'h5A5A, 1'b0);
    expQ.push_back(16'h5A5A);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1);
    checkOutput("enter_clear_valid", o_instr_valid, 0);
    checkOutput("enter_clear_ready", o_ready, 0);
    for (int i = 0; i < 8; i++) idle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_instr", o_instr_out, 0);
    checkOutput("midreset_valid", o_instr_valid, 0);
    checkOutput("midreset_ready", o_ready, 0);
    checkOutput("midreset_ldign", o_load_ignored, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      idle();
      checkOutput("rerun_ready", o_ready, (i == 16));
    end
    expQ.push_back(16'h0000);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0);
    idle();
    checkOutput("queue_empty", expQ.size(), 0);

    printSummary();
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
# instr_fetch_mem

Parametrised instruction memory for the RISC-16 core. It adds a registered fetch port with a stall-aware valid handshake, and a loader write port for programming. A hardware clear sequencer zeroes every word after reset and on demand. The block sits between the PC register and the decode stage, replacing the unclocked, zero-initialised instruction store.

## Interface
- `DATA_W`, default 16: instruction width in bits.
- `ADDR_W`, default 16: address width. `DEPTH = 2**ADDR_W` words, so no address is out of range.
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `fetch_req`, input, 1: request a read of `mem[pc_out]`.
- `pc_out`, input, ADDR_W: fetch address.
- `stall`, input, 1: downstream stall. Holds the current fetch response.
- `instr_out`, output, DATA_W: registered fetched instruction.
- `instr_valid`, output, 1: `instr_out` holds a valid response.
- `ready`, output, 1: the block is in READY state and accepts fetch and load.
- `load_en`, input, 1: write `load_data` to `mem[load_addr]`.
- `load_addr`, input, ADDR_W: loader write address.
- `load_data`, input, DATA_W: loader write data.
- `clear_req`, input, 1: start a full-memory clear.
- `load_ignored`, output, 1: one-cycle pulse when a `load_en` was dropped.

## Operation
- Storage: `DEPTH` x `DATA_W` array. `rst_n` does not reset the array; it is zeroed only by the clear sequencer.
- State machine has two states, CLEAR and READY.
  - CLEAR: each cycle writes 0 to `mem[clr_cnt]` and increments `clr_cnt`. When `clr_cnt == DEPTH-1` is written, the next state is READY.
  - READY: services fetch and load. `clear_req=1` moves to CLEAR with `clr_cnt=0` on the next edge.
- Reset: state=CLEAR, `clr_cnt=0`, `ready=0`, `instr_out=0`, `instr_valid=0`, `load_ignored=0`.
- `ready` is a registered output and equals (state == READY).
- Fetch, in READY with `stall=0`:
  - `fetch_req=1`: next edge sets `instr_out=mem[pc_out]` and `instr_valid=1`.
  - `fetch_req=0`: next edge sets `instr_valid=0`; `instr_out` holds its last value.
- Stall: while `stall=1`, `instr_out` and `instr_valid` hold regardless of `fetch_req`, `pc_out` or state. The pending request is not queued; the requester re-presents it after the stall.
- Load in READY: `load_en=1` writes on the edge.
- Load and fetch to the same address in the same cycle is write-first: `instr_out` receives `load_data`.
- Load in CLEAR, or in the same cycle as `clear_req`: the write is dropped and `load_ignored` pulses for 1 cycle on the next edge.
- `clear_req` while already in CLEAR: the clear restarts, `clr_cnt=0`.
- Entering CLEAR, by reset or `clear_req`, with `stall=0` sets `instr_valid=0` on the entering edge. During CLEAR with `stall=0`, `instr_valid` stays 0 and `fetch_req` is ignored.
- Reset asserted mid-operation: outputs return to reset values immediately, and the clear restarts from address 0 after release.

## Timing
- Fetch latency: 1 cycle, request edge to valid data.
- Throughput: one fetch per cycle, and one load per cycle concurrently.
- Clear duration: exactly `DEPTH` cycles. `ready` rises on edge `DEPTH` after `rst_n` release, or after the edge that sampled `clear_req`.
- Load write to a later fetch: data is readable by a fetch issued in the cycle after the load edge, and in the same cycle via write-first.
- `load_ignored`: asserted for exactly the one cycle following the dropped request.

## Test plan
All scenarios use `ADDR_W=4`, `DEPTH=16`, `DATA_W=16`.
- Release `rst_n`, then fetch all 16 addresses: `ready` rises after 16 edges, each fetch returns `0x0000` with `instr_valid=1` one cycle after `fetch_req`.
- Load `0xBEEF`@3 and `0x1234`@4, then fetch 3 then 4 back-to-back: `instr_out` is `0xBEEF` then `0x1234` on consecutive cycles.
- Same cycle: load `0xA5A5`@5 and fetch `pc_out=5`: `instr_out=0xA5A5` next cycle. Fetch 5 again later: still `0xA5A5`.
- Fetch 3, then raise `stall` for 4 cycles while changing `pc_out`: `instr_out` holds `0xBEEF` with `instr_valid=1`. After `stall` drops, a new fetch of 4 returns `0x1234`.
- Pulse `clear_req` with `load_en=1`@7 in the same cycle: `load_ignored` pulses once, `ready=0` for 16 cycles, and afterwards fetch 3 returns `0x0000`.
- Assert `rst_n=0` at `clr_cnt=8` mid-clear: outputs reset asynchronously. After release, `ready` rises exactly 16 edges later.
